hv_timing_gen: RTL and testbench
================================

Name: hv_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 9-bit HV generator used by the arcade cores.
- Generates pixel position, blanking, sync and a raster-line interrupt, plus a one-pixel registered RGB pipe.
- Sits between the video pipeline and the scan-converter/HDMI path; one instance per core.
- New versus the previous generation:
  - Totals and windows are set by parameters.
  - Sync offsets and the width mode are shadow-latched at frame boundaries, so changes never cause tearing.
  - Programmable line-compare IRQ and vblank-start pulse are added.

Parameters:
- CNTW, 9, counter width in bits for hcnt/vcnt/HPOS/VPOS.
- COLW, 4, bits per colour channel; iRGB/oRGB are 3*COLW wide.
- HTOTAL, 384, pixels per line (hcnt runs 0..HTOTAL-1).
- VTOTAL, 262, lines per frame (vcnt runs 0..VTOTAL-1).
- HPOS_OFS, 16, HPOS = hcnt - HPOS_OFS, mod 2^CNTW.
- HB_END_W / HB_START_W, 30 / 286, wide-mode active window (HBLK=0 for hcnt in [30,286)).
- HB_END_N / HB_START_N, 38 / 278, narrow-mode active window.
- HS_START, 288, nominal hsync start pixel.
- HS_WIDTH, 32, hsync width in pixels.
- VB_START, 224, first blanked line; lines 0..VB_START-1 are active.
- VS_START, 226, nominal vsync start line.
- VS_LINES, 4, vsync width in lines.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- PCLK_EN  in  1  pixel-clock enable; all state advances only when high (RESET excepted).
- iRGB  in  3*COLW  pixel from video pipeline.
- HOFFS  in  4  signed hsync shift, units of 2 pixels.
- VOFFS  in  4  signed vsync shift, units of 4 lines.
- NARROW  in  1  1 = narrow window (formerly 240-wide mode).
- LINE_CMP  in  CNTW  raster line for LINE_IRQ.
- HPOS  out  CNTW  hcnt - HPOS_OFS.
- VPOS  out  CNTW  vcnt.
- oRGB  out  3*COLW  registered pixel.
- HBLK  out  1  horizontal blank.
- VBLK  out  1  vertical blank.
- HSYN  out  1  hsync, active low.
- VSYN  out  1  vsync, active low.
- LINE_IRQ  out  1  one-PCLK_EN-cycle pulse.
- VBL_PULSE  out  1  one-PCLK_EN-cycle pulse at vblank start.

Behaviour:
- Reset values: hcnt=0, vcnt=0, HBLK=1, VBLK=1, HSYN=1, VSYN=1, oRGB=0, LINE_IRQ=0, VBL_PULSE=0.
  - Shadow registers reset to HOFFS=0, VOFFS=0, NARROW=0.
  - Reset wins over PCLK_EN and takes effect on the next CLK regardless of PCLK_EN.
- Counters:
  - On PCLK_EN, hcnt increments and wraps HTOTAL-1 -> 0.
  - On that wrap, vcnt increments and wraps VTOTAL-1 -> 0.
  - No counter jumps; sync placement never alters the counts.
- Frame boundary: the PCLK_EN cycle with hcnt=HTOTAL-1 and vcnt=VTOTAL-1.
  - Shadow regs capture HOFFS, VOFFS and NARROW on this cycle.
  - All timing below uses only the shadow values. Inputs changed mid-frame take effect from the next frame's line 0.
- Sync arithmetic:
  - hs_b = HS_START + 2*HOFFS_sh, sign-extended to CNTW+1, then reduced mod HTOTAL.
  - vs_b = VS_START + 4*VOFFS_sh, reduced mod VTOTAL.
  - HSYN=0 for HS_WIDTH pixels starting at hs_b; the window wraps across hcnt=0 when needed.
  - VSYN=0 for VS_LINES lines starting at vs_b, wrapping across vcnt=0. VSYN edges align to hcnt=0.
- Output timing: all outputs are registered. When the enabled edge sees counter value X, each output reflects X after that edge.
- HBLK:
  - Falls at hcnt=HB_END_x and rises at hcnt=HB_START_x, where x is selected by NARROW_sh.
  - If the mode changes at the frame boundary while HBLK=1, there is no glitch: HBLK stays 1 until the new HB_END.
- VBLK: rises at hcnt=HTOTAL-1 of line VB_START-1; falls at hcnt=HTOTAL-1 of line VTOTAL-1.
- VBL_PULSE: 1 for exactly the PCLK_EN cycle in which VBLK rises.
- LINE_IRQ:
  - 1 for one PCLK_EN cycle when vcnt==LINE_CMP and hcnt==HB_START_x.
  - LINE_CMP >= VTOTAL never fires.
  - LINE_CMP is sampled live, not shadowed.
- Pulse width: pulses clear on the next PCLK_EN cycle. With PCLK_EN=1 every clock, each pulse is one CLK wide.
- RGB: oRGB <= iRGB on PCLK_EN, one enabled-pixel latency.
- Elaboration: parameter sanity checks, each a fatal error:
  - HTOTAL <= 2^CNTW
  - VTOTAL <= 2^CNTW
  - HS_WIDTH < HTOTAL
  - VS_LINES < VTOTAL

Optional Feature:
- Macro HV_TIMING_BLANK_RGB_EN.
- Defined: oRGB is loaded with 0 on any PCLK_EN cycle where the next HBLK or VBLK value is 1, so black aligns with blank.
- Undefined: oRGB passes iRGB unconditionally, with blanking left to downstream logic.

Test Plan:
- Reset, PCLK_EN=1, defaults:
  - HSYN low for hcnt 288..319, period 384 clocks.
  - VSYN low on lines 226..229.
  - VBLK=1 on lines 224..261.
  - HPOS reads 0 when hcnt=16.
- HOFFS=-3 written at line 100:
  - Current frame HSYN still falls at 288.
  - Every line from the next frame falls at 282.
  - HOFFS=+7 gives 302, and its window 302..333 stays within 384.
- VOFFS=+2, then -7 in the following frame:
  - VSYN low on lines 234..237.
  - Next frame: start = 226-28 = 198, so VSYN is low on lines 198..201.
- NARROW 0->1 mid-frame: HBLK window stays 30..285 until the frame end, then becomes 38..277, with no extra HBLK edges.
- Line compare:
  - LINE_CMP=100 gives one LINE_IRQ pulse at vcnt=100, hcnt=286 per frame.
  - LINE_CMP=300 gives none.
  - VBL_PULSE occurs exactly once per 384*262 clocks.
- RESET=1 mid-line with PCLK_EN=0 gives reset values after one CLK.
  - With the macro defined: oRGB=0 while HBLK=1 and iRGB=12'hFFF.

Source files
------------

// File: rtl/hv_timing_gen.sv
// -----------------------------------------------------------------------------
// hv_timing_gen
//
// Parametrised raster timing generator. It produces the pixel position,
// horizontal and vertical blanking, active-low syncs, a line-compare interrupt
// and a vblank-start pulse, and passes pixels through a one-pixel register.
//
// All state advances only on cycles where PCLK_EN is high. RESET is
// synchronous and active high, and it wins over PCLK_EN. Every output is
// registered. When an enabled edge sees counter value X, each output shows
// the value decoded from X after that edge.
//
// The sync offsets (HOFFS, VOFFS) and the width mode (NARROW) pass through
// shadow registers. The shadows load only on the last pixel of the frame, so
// a mid-frame change takes effect from line 0 of the next frame.
//
// Optional feature, macro HV_TIMING_BLANK_RGB_EN:
//   defined   - oRGB loads 0 whenever the HBLK or VBLK value being loaded is 1
//   undefined - oRGB loads iRGB on every enabled cycle
//
// Ports:
//   CLK        in   system clock
//   RESET      in   synchronous active-high reset
//   PCLK_EN    in   pixel-clock enable
//   iRGB       in   [3*COLW] pixel from the video pipeline
//   HOFFS      in   [4] signed hsync shift, units of 2 pixels
//   VOFFS      in   [4] signed vsync shift, units of 4 lines
//   NARROW     in   1 = narrow active window
//   LINE_CMP   in   [CNTW] raster line for LINE_IRQ (live, not shadowed)
//   HPOS       out  [CNTW] hcnt - HPOS_OFS
//   VPOS       out  [CNTW] vcnt
//   oRGB       out  [3*COLW] registered pixel
//   HBLK       out  horizontal blank
//   VBLK       out  vertical blank
//   HSYN       out  hsync, active low
//   VSYN       out  vsync, active low
//   LINE_IRQ   out  one-enabled-cycle pulse at (LINE_CMP, HB_START_x)
//   VBL_PULSE  out  one-enabled-cycle pulse in the cycle where VBLK rises
// -----------------------------------------------------------------------------
module hv_timing_gen #(
    parameter int CNTW       = 9,
    parameter int COLW       = 4,
    parameter int HTOTAL     = 384,
    parameter int VTOTAL     = 262,
    parameter int HPOS_OFS   = 16,
    parameter int HB_END_W   = 30,
    parameter int HB_START_W = 286,
    parameter int HB_END_N   = 38,
    parameter int HB_START_N = 278,
    parameter int HS_START   = 288,
    parameter int HS_WIDTH   = 32,
    parameter int VB_START   = 224,
    parameter int VS_START   = 226,
    parameter int VS_LINES   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PCLK_EN,
    input  logic [3*COLW-1:0]   iRGB,
    input  logic [3:0]          HOFFS,
    input  logic [3:0]          VOFFS,
    input  logic                NARROW,
    input  logic [CNTW-1:0]     LINE_CMP,
    output logic [CNTW-1:0]     HPOS,
    output logic [CNTW-1:0]     VPOS,
    output logic [3*COLW-1:0]   oRGB,
    output logic                HBLK,
    output logic                VBLK,
    output logic                HSYN,
    output logic                VSYN,
    output logic                LINE_IRQ,
    output logic                VBL_PULSE
);

    // Parameter sanity checks. Each one stops elaboration.
    if (HTOTAL > (1 << CNTW)) begin : g_bad_htotal
        $fatal(1, "hv_timing_gen: HTOTAL does not fit in CNTW bits");
    end
    if (VTOTAL > (1 << CNTW)) begin : g_bad_vtotal
        $fatal(1, "hv_timing_gen: VTOTAL does not fit in CNTW bits");
    end
    if (HS_WIDTH >= HTOTAL) begin : g_bad_hswidth
        $fatal(1, "hv_timing_gen: HS_WIDTH must be below HTOTAL");
    end
    if (VS_LINES >= VTOTAL) begin : g_bad_vslines
        $fatal(1, "hv_timing_gen: VS_LINES must be below VTOTAL");
    end

    // The sync arithmetic uses two spare bits. The top bit flags a negative
    // sum, and the next bit holds sums that reach past one full total.
    localparam int SW = CNTW + 2;

    localparam logic [CNTW-1:0] H_LAST     = CNTW'(HTOTAL - 1);
    localparam logic [CNTW-1:0] V_LAST     = CNTW'(VTOTAL - 1);
    localparam logic [CNTW-1:0] VB_FIRST   = CNTW'(VB_START);
    localparam logic [CNTW-1:0] VB_PRE     = CNTW'(VB_START - 1);
    localparam logic [CNTW-1:0] HPOS_OFS_C = CNTW'(HPOS_OFS);
    localparam logic [CNTW-1:0] HBE_W      = CNTW'(HB_END_W);
    localparam logic [CNTW-1:0] HBS_W      = CNTW'(HB_START_W);
    localparam logic [CNTW-1:0] HBE_N      = CNTW'(HB_END_N);
    localparam logic [CNTW-1:0] HBS_N      = CNTW'(HB_START_N);
    localparam logic [SW-1:0]   H_TOT_S    = SW'(HTOTAL);
    localparam logic [SW-1:0]   V_TOT_S    = SW'(VTOTAL);
    localparam logic [SW-1:0]   HS_START_S = SW'(HS_START);
    localparam logic [SW-1:0]   VS_START_S = SW'(VS_START);
    localparam logic [SW-1:0]   HS_WIDTH_S = SW'(HS_WIDTH);
    localparam logic [SW-1:0]   VS_LINES_S = SW'(VS_LINES);

    // Raster counters and the frame-boundary shadow registers
    logic [CNTW-1:0]   r_hcnt;
    logic [CNTW-1:0]   r_vcnt;
    logic [3:0]        r_hoffs_sh;
    logic [3:0]        r_voffs_sh;
    logic              r_narrow_sh;

    // Output registers
    logic [CNTW-1:0]   r_hpos;
    logic [CNTW-1:0]   r_vpos;
    logic [3*COLW-1:0] r_rgb;
    logic              r_hblk;
    logic              r_vblk;
    logic              r_hsyn;
    logic              r_vsyn;
    logic              r_line_irq;
    logic              r_vbl_pulse;

    // Next-state decode
    logic              w_h_last;
    logic              w_frame_end;
    logic [CNTW-1:0]   w_hcnt_nxt;
    logic [CNTW-1:0]   w_vcnt_nxt;
    logic [CNTW-1:0]   w_hb_end;
    logic [CNTW-1:0]   w_hb_start;
    logic              w_hblk_nxt;
    logic              w_vblk_nxt;
    logic              w_irq_nxt;
    logic              w_vbl_nxt;
    logic [SW-1:0]     w_hoffs_ext;
    logic [SW-1:0]     w_voffs_ext;
    logic [SW-1:0]     w_hs_raw;
    logic [SW-1:0]     w_vs_raw;
    logic [SW-1:0]     w_hs_b;
    logic [SW-1:0]     w_vs_b;
    logic [SW-1:0]     w_hcnt_ext;
    logic [SW-1:0]     w_vcnt_ext;
    logic [SW-1:0]     w_h_dist;
    logic [SW-1:0]     w_v_dist;
    logic              w_hsyn_nxt;
    logic              w_vsyn_nxt;
    logic [3*COLW-1:0] w_rgb_nxt;

    // NOTE: every signal assigned in this block gets a default value first.
    // Then no path can leave a signal unassigned, so no latch is inferred.
    always_comb begin
        w_h_last    = (r_hcnt == H_LAST);
        w_frame_end = w_h_last && (r_vcnt == V_LAST);
        w_hcnt_nxt  = r_hcnt + 1'b1;
        w_vcnt_nxt  = r_vcnt;
        w_hb_end    = HBE_W;
        w_hb_start  = HBS_W;

        if (w_h_last) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end

        if (r_narrow_sh) begin
            w_hb_end   = HBE_N;
            w_hb_start = HBS_N;
        end

        // HBLK is decoded only from hcnt, and hcnt never jumps. At the frame
        // boundary hcnt is in blank under both modes, so a mode change
        // cannot add an HBLK edge.
        w_hblk_nxt = !((r_hcnt >= w_hb_end) && (r_hcnt < w_hb_start));

        // VBLK follows the line the counter is moving into. It therefore
        // changes on the last pixel of the line before the blank boundary.
        w_vblk_nxt = (w_vcnt_nxt >= VB_FIRST);
        w_vbl_nxt  = w_h_last && (r_vcnt == VB_PRE);
        w_irq_nxt  = (r_vcnt == LINE_CMP) && (r_hcnt == w_hb_start);

        // Sync start = nominal + scaled signed offset, folded into
        // [0, total). A single correction is enough because an offset is
        // always much smaller than one total.
        w_hoffs_ext = {{(SW-4){r_hoffs_sh[3]}}, r_hoffs_sh};
        w_voffs_ext = {{(SW-4){r_voffs_sh[3]}}, r_voffs_sh};
        w_hs_raw    = HS_START_S + (w_hoffs_ext << 1);
        w_vs_raw    = VS_START_S + (w_voffs_ext << 2);

        w_hs_b = w_hs_raw;
        if (w_hs_raw[SW-1]) begin
            w_hs_b = w_hs_raw + H_TOT_S;
        end else if (w_hs_raw >= H_TOT_S) begin
            w_hs_b = w_hs_raw - H_TOT_S;
        end

        w_vs_b = w_vs_raw;
        if (w_vs_raw[SW-1]) begin
            w_vs_b = w_vs_raw + V_TOT_S;
        end else if (w_vs_raw >= V_TOT_S) begin
            w_vs_b = w_vs_raw - V_TOT_S;
        end

        // Distance from the sync start, modulo the total. This lets a pulse
        // wrap across count 0 without a separate case.
        w_hcnt_ext = {2'b00, r_hcnt};
        w_vcnt_ext = {2'b00, r_vcnt};
        w_h_dist   = (w_hcnt_ext >= w_hs_b) ? (w_hcnt_ext - w_hs_b)
                                            : (w_hcnt_ext + H_TOT_S - w_hs_b);
        w_v_dist   = (w_vcnt_ext >= w_vs_b) ? (w_vcnt_ext - w_vs_b)
                                            : (w_vcnt_ext + V_TOT_S - w_vs_b);
        // VSYN decodes vcnt alone. Its edges therefore land on the first
        // pixel of a line.
        w_hsyn_nxt = !(w_h_dist < HS_WIDTH_S);
        w_vsyn_nxt = !(w_v_dist < VS_LINES_S);

`ifdef HV_TIMING_BLANK_RGB_EN
        w_rgb_nxt = (w_hblk_nxt || w_vblk_nxt) ? '0 : iRGB;
`else
        w_rgb_nxt = iRGB;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from values sampled before the edge, whatever
    // order the statements are written in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_hoffs_sh  <= '0;
            r_voffs_sh  <= '0;
            r_narrow_sh <= 1'b0;
            r_hpos      <= '0 - HPOS_OFS_C;
            r_vpos      <= '0;
            r_rgb       <= '0;
            r_hblk      <= 1'b1;
            r_vblk      <= 1'b1;
            r_hsyn      <= 1'b1;
            r_vsyn      <= 1'b1;
            r_line_irq  <= 1'b0;
            r_vbl_pulse <= 1'b0;
        end else if (PCLK_EN) begin
            r_hcnt      <= w_hcnt_nxt;
            r_vcnt      <= w_vcnt_nxt;
            if (w_frame_end) begin
                r_hoffs_sh  <= HOFFS;
                r_voffs_sh  <= VOFFS;
                r_narrow_sh <= NARROW;
            end
            r_hpos      <= r_hcnt - HPOS_OFS_C;
            r_vpos      <= r_vcnt;
            r_rgb       <= w_rgb_nxt;
            r_hblk      <= w_hblk_nxt;
            r_vblk      <= w_vblk_nxt;
            r_hsyn      <= w_hsyn_nxt;
            r_vsyn      <= w_vsyn_nxt;
            r_line_irq  <= w_irq_nxt;
            r_vbl_pulse <= w_vbl_nxt;
        end
    end

    assign HPOS      = r_hpos;
    assign VPOS      = r_vpos;
    assign oRGB      = r_rgb;
    assign HBLK      = r_hblk;
    assign VBLK      = r_vblk;
    assign HSYN      = r_hsyn;
    assign VSYN      = r_vsyn;
    assign LINE_IRQ  = r_line_irq;
    assign VBL_PULSE = r_vbl_pulse;

endmodule

// File: tb/tb_hv_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_hv_timing_gen
//
// Directed bench for hv_timing_gen. Horizontal timing uses the default values.
// The frame is shortened to 32 lines (VB_START 24, VS_START 26) so that
// several complete frames fit in a short run. Each line is measured
// (sync start and width, blank edges, pulse counts), and the measurements
// are compared with per-frame values computed by hand.
// -----------------------------------------------------------------------------
module tb_hv_timing_gen;

    localparam int VT    = 32;
    localparam int HT    = 384;
    localparam int FRAME = HT * VT;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PCLK_EN;
    logic [11:0] iRGB;
    logic [3:0]  HOFFS;
    logic [3:0]  VOFFS;
    logic        NARROW;
    logic [8:0]  LINE_CMP;
    logic [8:0]  HPOS;
    logic [8:0]  VPOS;
    logic [11:0] oRGB;
    logic        HBLK;
    logic        VBLK;
    logic        HSYN;
    logic        VSYN;
    logic        LINE_IRQ;
    logic        VBL_PULSE;

    hv_timing_gen #(
        .VTOTAL   (VT),
        .VB_START (24),
        .VS_START (26)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PCLK_EN   (PCLK_EN),
        .iRGB      (iRGB),
        .HOFFS     (HOFFS),
        .VOFFS     (VOFFS),
        .NARROW    (NARROW),
        .LINE_CMP  (LINE_CMP),
        .HPOS      (HPOS),
        .VPOS      (VPOS),
        .oRGB      (oRGB),
        .HBLK      (HBLK),
        .VBLK      (VBLK),
        .HSYN      (HSYN),
        .VSYN      (VSYN),
        .LINE_IRQ  (LINE_IRQ),
        .VBL_PULSE (VBL_PULSE)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Counter values seen by the most recent enabled edge, and the values
    // the next enabled edge will see
    int e_h, e_v, n_h = 0, n_v = 0;
    int clk_cnt = 0;
    logic [11:0] rgb_drv;
    logic [11:0] last_rgb = '0;

    // Per-frame expectations, set by hand in the stimulus
    int exp_hs, exp_vs, exp_narrow, exp_cmp;

    // Measurements for one line
    int hs_first, hs_cnt, hb_fall, hb_rise, hb_edges, vs_cnt, vb_cnt;
    int irq_cnt, irq_h, vbl_cnt, vbl_h, pos_bad, rgb_bad;
    int prev_hblk;
    int vbl_total = 0;
    int vbl_last_clk = -1;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (line %0d pix %0d)", tag, obs, exp, e_v, e_h);
        end
    endtask

    task automatic tick();
        rgb_drv = 12'($urandom);
        iRGB    = rgb_drv;
        @(posedge CLK);
        #1;
        clk_cnt++;
        if (RESET) begin
            n_h = 0;
            n_v = 0;
            last_rgb = '0;
        end else if (PCLK_EN) begin
            e_h = n_h;
            e_v = n_v;
            last_rgb = rgb_drv;
            if (n_h == HT - 1) begin
                n_h = 0;
                n_v = (n_v == VT - 1) ? 0 : n_v + 1;
            end else begin
                n_h = n_h + 1;
            end
        end
    endtask

`ifdef HV_TIMING_BLANK_RGB_EN
    function automatic bit model_blank(input int h, input int v, input int narrow);
        int nv;
        bit hb;
        nv = (h == HT - 1) ? ((v + 1) % VT) : v;
        hb = narrow ? !(h >= 38 && h < 278) : !(h >= 30 && h < 286);
        return hb || (nv >= 24);
    endfunction
`endif

    task automatic clear_stats();
        hs_first = -1; hs_cnt = 0; hb_fall = -1; hb_rise = -1; hb_edges = 0;
        vs_cnt = 0; vb_cnt = 0; irq_cnt = 0; irq_h = -1; vbl_cnt = 0; vbl_h = -1;
        pos_bad = 0; rgb_bad = 0;
    endtask

    task automatic run_pixels(input int n);
        logic [11:0] er;
        for (int i = 0; i < n; i++) begin
            PCLK_EN = 1'b1;
            tick();
            if (HSYN === 1'b0) begin
                if (hs_first < 0) hs_first = e_h;
                hs_cnt++;
            end
            if (prev_hblk == 1 && HBLK === 1'b0) begin hb_fall = e_h; hb_edges++; end
            if (prev_hblk == 0 && HBLK === 1'b1) begin hb_rise = e_h; hb_edges++; end
            prev_hblk = (HBLK === 1'b1) ? 1 : 0;
            if (VSYN === 1'b0) vs_cnt++;
            if (VBLK === 1'b1) vb_cnt++;
            if (LINE_IRQ === 1'b1) begin irq_cnt++; irq_h = e_h; end
            if (VBL_PULSE === 1'b1) begin
                vbl_cnt++;
                vbl_h = e_h;
                vbl_total++;
                if (vbl_last_clk >= 0) check("vbl_period", clk_cnt - vbl_last_clk, FRAME);
                vbl_last_clk = clk_cnt;
            end
            if (HPOS !== 9'(e_h - 16) || VPOS !== 9'(e_v)) pos_bad++;
            er = last_rgb;
`ifdef HV_TIMING_BLANK_RGB_EN
            if (model_blank(e_h, e_v, exp_narrow)) er = '0;
`endif
            if (oRGB !== er) rgb_bad++;
        end
    endtask

    task automatic run_line();
        int v;
        int hbe, hbs;
        clear_stats();
        run_pixels(HT);
        v   = e_v;
        hbe = exp_narrow ? 38 : 30;
        hbs = exp_narrow ? 278 : 286;
        check("hs_start", hs_first, exp_hs);
        check("hs_width", hs_cnt, 32);
        check("hb_fall", hb_fall, hbe);
        check("hb_rise", hb_rise, hbs);
        check("hb_edges", hb_edges, 2);
        check("vs_pixels", vs_cnt, (((v - exp_vs + VT) % VT) < 4) ? HT : 0);
        check("vb_pixels", vb_cnt, (v < 23) ? 0 : (v == 23) ? 1 : (v == VT - 1) ? HT - 1 : HT);
        check("irq_count", irq_cnt, (v == exp_cmp) ? 1 : 0);
        check("irq_pix", irq_h, (v == exp_cmp) ? hbs : -1);
        check("vbl_count", vbl_cnt, (v == 23) ? 1 : 0);
        check("vbl_pix", vbl_h, (v == 23) ? HT - 1 : -1);
        check("pos_bad", pos_bad, 0);
        check("rgb_bad", rgb_bad, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vpos"}, int'(VPOS), 0);
        check({tag, "_hblk"}, int'(HBLK), 1);
        check({tag, "_vblk"}, int'(VBLK), 1);
        check({tag, "_hsyn"}, int'(HSYN), 1);
        check({tag, "_vsyn"}, int'(VSYN), 1);
        check({tag, "_orgb"}, int'(oRGB), 0);
        check({tag, "_irq"}, int'(LINE_IRQ), 0);
        check({tag, "_vbl"}, int'(VBL_PULSE), 0);
    endtask

    initial begin
        RESET    = 1'b1;
        PCLK_EN  = 1'b0;
        iRGB     = '0;
        HOFFS    = 4'h0;
        VOFFS    = 4'h0;
        NARROW   = 1'b0;
        LINE_CMP = 9'd10;
        e_h = 0;
        e_v = 0;
        tick();
        tick();
        check_reset_values("reset");
        RESET = 1'b0;
        prev_hblk = (HBLK === 1'b1) ? 1 : 0;

        // Frame 0: defaults. HOFFS=-3 and VOFFS=+2 are written at line 10
        // but must not touch this frame.
        exp_hs = 288; exp_vs = 26; exp_narrow = 0; exp_cmp = 10;
        for (int v = 0; v < VT; v++) begin
            if (v == 10) begin
                HOFFS = 4'hD;
                VOFFS = 4'h2;
            end
            run_line();
        end

        // Frame 1: hsync at 288-6=282, vsync at 26+8=34 mod 32 = lines 2..5.
        // HOFFS=+7 and VOFFS=-7 are written at line 10, NARROW at line 15.
        exp_hs = 282; exp_vs = 2;
        for (int v = 0; v < VT; v++) begin
            if (v == 10) begin
                HOFFS = 4'h7;
                VOFFS = 4'h9;
            end
            if (v == 15) NARROW = 1'b1;
            run_line();
        end

        // Frame 2: hsync 302..333, vsync 26-28 -> 30, lines 30,31,0,1.
        // Narrow window 38..277. LINE_CMP beyond VTOTAL gives no interrupt.
        exp_hs = 302; exp_vs = 30; exp_narrow = 1; exp_cmp = 300;
        LINE_CMP = 9'd300;
        for (int v = 0; v < VT; v++) begin
            run_line();
        end
        check("vbl_total", vbl_total, 3);

        // Frame 3: the interrupt moves to line 1, pixel 278 (narrow window)
        exp_cmp = 1;
        LINE_CMP = 9'd1;
        run_line();
        clear_stats();
        run_pixels(279);
        check("irq_set", int'(LINE_IRQ), 1);
        PCLK_EN = 1'b0;
        repeat (3) tick();
        check("irq_hold", int'(LINE_IRQ), 1);
        check("hpos_hold", int'(HPOS), 262);
        run_pixels(1);
        check("irq_clear", int'(LINE_IRQ), 0);
        check("hpos_step", int'(HPOS), 263);
        run_pixels(31);
        check("pre_rst_hsyn", int'(HSYN), 0);
        check("pre_rst_vsyn", int'(VSYN), 0);
        check("pre_rst_vblk", int'(VBLK), 0);
        check("pre_rst_pos_bad", pos_bad, 0);
        check("pre_rst_rgb_bad", rgb_bad, 0);

        // Reset mid-line with PCLK_EN low acts within one clock
        PCLK_EN = 1'b0;
        RESET   = 1'b1;
        tick();
        check_reset_values("midrst");
        RESET = 1'b0;
        prev_hblk = (HBLK === 1'b1) ? 1 : 0;

        // The shadows are reset to 0. HOFFS=+7 and NARROW=1 on the inputs
        // are ignored until the next frame boundary.
        exp_hs = 288; exp_vs = 26; exp_narrow = 0;
        run_line();
        run_line();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
